idli_sqi_ctrl_m: RTL and testbench
==================================

# idli_sqi_ctrl_m

Nibble-serial SQI memory controller sitting between the core's nibble-wide address/data paths and the external quad-SPI SRAM. It accepts a 16-bit address streamed least-significant nibble first (the order the PC rotates out), reorders it into the MSB-first command/address sequence the SRAM expects, and then streams data nibbles in either direction until the core drops its request. It is the consumer end of the PC slice stream and the producer of the instruction/data nibbles the core fetches.

## Interface
- No parameters. Phase lengths and command codes come from `idli_pkg`.
- `i_sqi_gck`  in  1  core clock; SRAM SCK is derived externally from this clock, gated by `o_sqi_sck_en`.
- `i_sqi_rst`  in  1  reset, synchronous, active-high.
- `i_sqi_req`  in  1  transaction request; held high for the whole transaction; low ends it.
- `i_sqi_wr`  in  1  write when high, read when low; sampled only in the accept cycle.
- `i_sqi_data`  in  `sqi_data_t`  address nibbles in ADDR, then write data nibbles in DATA.
- `o_sqi_ready`  out  1  controller is idle and will accept `i_sqi_req` this cycle.
- `o_sqi_rd_data`  out  `sqi_data_t`  registered read nibble.
- `o_sqi_rd_valid`  out  1  `o_sqi_rd_data` holds memory data this cycle.
- `o_sqi_wr_ready`  out  1  `i_sqi_data` is consumed as write data this cycle.
- `o_sqi_cs_n`  out  1  SRAM chip select, active-low.
- `o_sqi_sck_en`  out  1  SCK gate; high in every cycle `o_sqi_cs_n` is low.
- `o_sqi_sio_out`  out  4  pad output nibble.
- `o_sqi_sio_oe`  out  1  pad output enable.
- `i_sqi_sio_in`  in  4  pad input nibble.

## Operation
- The SRAM is already in SQI mode when this block runs. Mode entry is not handled here.
- The FSM has the states IDLE, ADDR, CMD, AOUT, DUMMY, DATA, GAP.
- **IDLE:** `o_sqi_ready`=1 and `o_sqi_cs_n`=1.
  - When `i_sqi_req`=1, the block latches `i_sqi_wr`, captures `i_sqi_data` as addr[3:0], and goes to ADDR.
- **ADDR (3 cycles):** captures addr[7:4], addr[11:8] and addr[15:12] in that order. `o_sqi_cs_n` stays 1.
- **CMD (2 cycles):** `o_sqi_cs_n`=0 and `o_sqi_sio_oe`=1.
  - Read drives 0x0 then 0x3.
  - Write drives 0x0 then 0x2.
- **AOUT (6 cycles):** drives 0x0, 0x0, addr[15:12], addr[11:8], addr[7:4], addr[3:0].
- **DUMMY (2 cycles, reads only):** `o_sqi_sio_oe`=0 for bus turnaround.
- **DATA:**
  - Read:
    - `o_sqi_sio_oe`=0.
    - `i_sqi_sio_in` is registered into `o_sqi_rd_data`.
    - `o_sqi_rd_valid`=1 in the cycle after each DATA cycle.
  - Write:
    - `o_sqi_sio_oe`=1 and `o_sqi_wr_ready`=1.
    - `o_sqi_sio_out`=`i_sqi_data`, passed through combinationally.
  - Nibble order is passed through unchanged. No reordering of data.
- **Termination:** `i_sqi_req`=0 in any non-IDLE state moves the FSM to GAP on the next edge. This applies in DATA and is also an abort earlier.
  - The cycle in which `i_sqi_req` is low performs no transfer.
- **GAP (1 cycle):** `o_sqi_cs_n`=1 and `o_sqi_ready`=0, which guarantees the minimum CS-high time. Then IDLE.
- Address register: 16 bits, filled by shifting in at the top, `{nibble, addr[15:4]}`, so addr[3:0] ends up in the low nibble.

## Timing
- Reset values:
  - `o_sqi_cs_n`=1
  - `o_sqi_ready`=1
  - `o_sqi_sck_en`, `o_sqi_sio_oe`, `o_sqi_rd_valid`, `o_sqi_wr_ready` = 0
  - `o_sqi_sio_out` and `o_sqi_rd_data` = 0
  - FSM in IDLE.
- Reset asserted mid-transaction forces all of the above on the next edge, with no GAP cycle.
- Cycle 0 is the accept cycle.
  - Cycles 1–3: ADDR.
  - Cycles 4–5: CMD.
  - Cycles 6–11: AOUT.
- Reads: DUMMY in cycles 12–13, first DATA cycle 14, first `o_sqi_rd_valid` in cycle 15.
- Writes: first DATA cycle 12, with `o_sqi_wr_ready`=1 from cycle 12.
- Read data follows the core's request with a 1-cycle lag. `o_sqi_rd_valid` stays high for exactly one cycle after the last DATA cycle.
- Back-to-back transactions: the next accept can happen at the earliest 2 cycles after the `i_sqi_req`=0 cycle.

## Configuration
- `IDLI_SQI_WRITE_EN` defined: full read/write support as described above.
- `IDLI_SQI_WRITE_EN` undefined:
  - `i_sqi_wr` is ignored and every transaction is a read.
  - `o_sqi_wr_ready` is tied to 0.
  - Write-only command logic is removed.

## Structure
- The following go in `idli_pkg`:
  - `sqi_state_t` enum.
  - `SQI_CMD_READ`=8'h03 and `SQI_CMD_WRITE`=8'h02.
  - `SQI_ADDR_OUT_NIBBLES`=6 and `SQI_DUMMY_NIBBLES`=2.
  - Reuse of the existing `sqi_data_t`.
- One sub-module, `idli_sqi_addr_m`. It owns the 16-bit address capture shift register and the AOUT nibble select, indexed by a 3-bit phase counter.
- The FSM, phase counter and pad registers stay in the top-level module.

## Test plan
- **Read at 0x1234:** drive 4,3,2,1 on cycles 0–3.
  - Pins show 0,3 | 0,0,1,2,3,4 | oe=0 ×2.
  - Memory returns A,B,C,D from cycle 14; `o_sqi_rd_data` = A,B,C,D on cycles 15–18 with valid high.
- **Write at 0xBEEF** (macro defined): address nibbles F,E,E,B.
  - Pins show 0,2 | 0,0,B,E,E,F.
  - Data 5,6 is driven on cycles 12–13 with `o_sqi_wr_ready`=1 and oe=1. No DUMMY phase.
- **Abort:** drop `i_sqi_req` in cycle 7 (AOUT).
  - `o_sqi_cs_n`=1 from cycle 8; GAP in cycle 8; `o_sqi_ready`=1 in cycle 9.
- **Back-to-back reads:** the first read ends with req=0 in cycle 18.
  - The new request is held but is not accepted until cycle 20.
  - `o_sqi_cs_n` is high in cycles 18 and 19.
- **Reset mid-DATA:** assert `i_sqi_rst` in cycle 16 of a read.
  - Cycle 17 shows all outputs at their reset values.
  - A new read issued afterwards completes normally.
- **Macro undefined:** request with `i_sqi_wr`=1 at 0x0010.
  - The read command 0x0,0x3 is issued and DUMMY is present.
  - `o_sqi_wr_ready` stays 0 throughout.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI memory path.
package idli_pkg;

  // One nibble on the core's serial address/data path.
  typedef logic [3:0] sqi_data_t;

  // Controller FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StCmd,
    StAout,
    StDummy,
    StData,
    StGap
  } sqi_state_t;

  // SQI command bytes, sent as two nibbles, high nibble first.
  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  localparam int unsigned SQI_ADDR_IN_NIBBLES  = 3;  // nibbles after the accept cycle
  localparam int unsigned SQI_CMD_NIBBLES      = 2;
  localparam int unsigned SQI_ADDR_OUT_NIBBLES = 6;
  localparam int unsigned SQI_DUMMY_NIBBLES    = 2;

  // Last phase-counter value of a phase that lasts n cycles.
  function automatic logic [2:0] sqi_last(input int unsigned n);
    return 3'(n - 1);
  endfunction

endpackage

// File: rtl/idli_sqi_addr_m.sv
// Address capture and AOUT nibble select for the SQI controller.
// Nibbles arrive LSN first and are shifted in at the top, so after four
// shifts the first nibble sits in addr[3:0].
module idli_sqi_addr_m
  import idli_pkg::*;
(
  input  logic      i_gck,
  input  logic      i_rst,
  input  logic      i_shift,
  input  sqi_data_t i_nibble,
  input  logic [2:0] i_phase,
  output sqi_data_t o_nibble
);

  logic [15:0] addr_q, addr_d;

  // Shift a new nibble in from the top when enabled.
  always_comb begin
    addr_d = addr_q;
    if (i_shift) begin
      addr_d = {i_nibble, addr_q[15:4]};
    end
  end

  // Address register.
  always_ff @(posedge i_gck) begin
    if (i_rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // AOUT sends two zero nibbles (A23..A16) then the address MSN first.
  always_comb begin
    o_nibble = '0;
    case (i_phase)
      3'd2:    o_nibble = addr_q[15:12];
      3'd3:    o_nibble = addr_q[11:8];
      3'd4:    o_nibble = addr_q[7:4];
      3'd5:    o_nibble = addr_q[3:0];
      default: o_nibble = '0;
    endcase
  end

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// Nibble-serial SQI SRAM controller: captures an LSN-first 16-bit address,
// issues command + MSN-first address, then streams data until i_sqi_req drops.
// Define IDLI_SQI_WRITE_EN for write support; otherwise every access is a read.
module idli_sqi_ctrl_m
  import idli_pkg::*;
(
  input  logic       i_sqi_gck,
  input  logic       i_sqi_rst,
  input  logic       i_sqi_req,
  input  logic       i_sqi_wr,
  input  sqi_data_t  i_sqi_data,
  output logic       o_sqi_ready,
  output sqi_data_t  o_sqi_rd_data,
  output logic       o_sqi_rd_valid,
  output logic       o_sqi_wr_ready,
  output logic       o_sqi_cs_n,
  output logic       o_sqi_sck_en,
  output logic [3:0] o_sqi_sio_out,
  output logic       o_sqi_sio_oe,
  input  logic [3:0] i_sqi_sio_in
);

  sqi_state_t state_q, state_d;
  logic [2:0] phase_q, phase_d;
  sqi_data_t  rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       is_wr;
  logic       addr_shift;
  sqi_data_t  aout_nibble;
  logic [7:0] cmd_byte;
  sqi_data_t  cmd_nibble;
  logic       active;
  logic       xfer;

`ifdef IDLI_SQI_WRITE_EN
  logic wr_q, wr_d;

  // Direction is latched in the accept cycle only.
  always_comb begin
    wr_d = wr_q;
    if (state_q == StIdle && i_sqi_req) begin
      wr_d = i_sqi_wr;
    end
  end

  // Direction register.
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
    end
  end

  assign is_wr    = wr_q;
  assign cmd_byte = wr_q ? SQI_CMD_WRITE : SQI_CMD_READ;
`else
  logic unused_wr;
  assign unused_wr = i_sqi_wr;
  assign is_wr     = 1'b0;
  assign cmd_byte  = SQI_CMD_READ;
`endif

  assign addr_shift = i_sqi_req && (state_q == StIdle || state_q == StAddr);
  assign cmd_nibble = phase_q[0] ? cmd_byte[3:0] : cmd_byte[7:4];

  idli_sqi_addr_m u_addr (
    .i_gck    (i_sqi_gck),
    .i_rst    (i_sqi_rst),
    .i_shift  (addr_shift),
    .i_nibble (i_sqi_data),
    .i_phase  (phase_q),
    .o_nibble (aout_nibble)
  );

  // Next-state and phase counter; a dropped request always exits via GAP.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 3'd1;
    unique case (state_q)
      StIdle: begin
        phase_d = '0;
        if (i_sqi_req) state_d = StAddr;
      end
      StAddr: begin
        if (phase_q == sqi_last(SQI_ADDR_IN_NIBBLES)) begin
          state_d = StCmd;
          phase_d = '0;
        end
      end
      StCmd: begin
        if (phase_q == sqi_last(SQI_CMD_NIBBLES)) begin
          state_d = StAout;
          phase_d = '0;
        end
      end
      StAout: begin
        if (phase_q == sqi_last(SQI_ADDR_OUT_NIBBLES)) begin
          state_d = is_wr ? StData : StDummy;
          phase_d = '0;
        end
      end
      StDummy: begin
        if (phase_q == sqi_last(SQI_DUMMY_NIBBLES)) begin
          state_d = StData;
          phase_d = '0;
        end
      end
      StData: phase_d = '0;
      StGap: begin
        state_d = StIdle;
        phase_d = '0;
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase
    if (!i_sqi_req && state_q != StIdle && state_q != StGap) begin
      state_d = StGap;
      phase_d = '0;
    end
  end

  // A cycle with the request low never transfers and already has CS released.
  assign xfer   = i_sqi_req && (state_q == StData);
  assign active = i_sqi_req && (state_q == StCmd || state_q == StAout ||
                                state_q == StDummy || state_q == StData);

  // Read capture: pad nibble lands in rd_data one cycle after the DATA cycle.
  always_comb begin
    rd_valid_d = xfer && !is_wr;
    rd_data_d  = rd_valid_d ? i_sqi_sio_in : rd_data_q;
  end

  // FSM, phase counter and read pad registers.
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Pad and handshake outputs.
  always_comb begin
    o_sqi_sio_out = '0;
    case (state_q)
      StCmd:   o_sqi_sio_out = cmd_nibble;
      StAout:  o_sqi_sio_out = aout_nibble;
      StData:  if (is_wr) o_sqi_sio_out = i_sqi_data;
      default: o_sqi_sio_out = '0;
    endcase
    o_sqi_sio_oe   = i_sqi_req && (state_q == StCmd || state_q == StAout ||
                                   (state_q == StData && is_wr));
    o_sqi_cs_n     = !active;
    o_sqi_sck_en   = active;
    o_sqi_ready    = (state_q == StIdle);
    o_sqi_wr_ready = xfer && is_wr;
    o_sqi_rd_valid = rd_valid_q;
    o_sqi_rd_data  = rd_data_q;
  end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed self-checking bench for idli_sqi_ctrl_m.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Cycle c of a scenario is the c-th such interval.
module tb_idli_sqi_ctrl_m;

  logic       clk = 1'b0;
  logic       rst, req, wr;
  logic [3:0] data, sio_in;
  logic       ready, rd_valid, wr_ready, cs_n, sck_en, sio_oe;
  logic [3:0] rd_data, sio_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  idli_sqi_ctrl_m dut (
    .i_sqi_gck      (clk),
    .i_sqi_rst      (rst),
    .i_sqi_req      (req),
    .i_sqi_wr       (wr),
    .i_sqi_data     (data),
    .o_sqi_ready    (ready),
    .o_sqi_rd_data  (rd_data),
    .o_sqi_rd_valid (rd_valid),
    .o_sqi_wr_ready (wr_ready),
    .o_sqi_cs_n     (cs_n),
    .o_sqi_sck_en   (sck_en),
    .o_sqi_sio_out  (sio_out),
    .o_sqi_sio_oe   (sio_oe),
    .i_sqi_sio_in   (sio_in)
  );

  // Expected pad nibble in cycles 4..11 after an accept in cycle 0.
  function automatic logic [3:0] exp_pin(input int c, input logic w, input logic [15:0] a);
    case (c)
      5:       return w ? 4'h2 : 4'h3;
      8:       return a[15:12];
      9:       return a[11:8];
      10:      return a[7:4];
      11:      return a[3:0];
      default: return 4'h0;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; wr = 1'b0; data = 4'h0; sio_in = 4'h0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({ready, cs_n, sck_en, sio_oe, rd_valid, wr_ready} !== 6'b110000) begin
      errors++;
      $display("FAIL reset ctrl got %b want 110000",
               {ready, cs_n, sck_en, sio_oe, rd_valid, wr_ready});
    end
    checks++;
    if ({sio_out, rd_data} !== 8'h00) begin
      errors++;
      $display("FAIL reset data got %h want 00", {sio_out, rd_data});
    end
    rst = 1'b0;
    next_cycle();
  endtask

  // Read at 0x1234, memory returns A,B,C,D in cycles 14..17, req drops in 18.
  task automatic test_read();
    logic [15:0] a = 16'h1234;
    logic [3:0] mem [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    for (int c = 0; c <= 20; c++) begin
      logic exp_cs, exp_oe, exp_v, exp_rdy;
      req = (c <= 17); wr = 1'b0;
      data = (c < 4) ? a[4*c +: 4] : 4'h0;
      sio_in = (c >= 14 && c <= 17) ? mem[c-14] : 4'h0;
      @(negedge clk);
      exp_cs  = !(c >= 4 && c <= 17);
      exp_oe  = (c >= 4 && c <= 11);
      exp_v   = (c >= 15 && c <= 18);
      exp_rdy = (c == 0 || c == 20);
      checks++;
      if (cs_n !== exp_cs) begin
        errors++; $display("FAIL read c%0d cs_n got %b want %b", c, cs_n, exp_cs);
      end
      checks++;
      if (sck_en !== !exp_cs) begin
        errors++; $display("FAIL read c%0d sck_en got %b want %b", c, sck_en, !exp_cs);
      end
      checks++;
      if (sio_oe !== exp_oe) begin
        errors++; $display("FAIL read c%0d oe got %b want %b", c, sio_oe, exp_oe);
      end
      checks++;
      if (rd_valid !== exp_v) begin
        errors++; $display("FAIL read c%0d rd_valid got %b want %b", c, rd_valid, exp_v);
      end
      checks++;
      if (ready !== exp_rdy) begin
        errors++; $display("FAIL read c%0d ready got %b want %b", c, ready, exp_rdy);
      end
      checks++;
      if (wr_ready !== 1'b0) begin
        errors++; $display("FAIL read c%0d wr_ready got %b want 0", c, wr_ready);
      end
      if (exp_oe) begin
        checks++;
        if (sio_out !== exp_pin(c, 1'b0, a)) begin
          errors++;
          $display("FAIL read c%0d sio_out got %h want %h", c, sio_out, exp_pin(c, 1'b0, a));
        end
      end
      if (exp_v) begin
        checks++;
        if (rd_data !== mem[c-15]) begin
          errors++; $display("FAIL read c%0d rd_data got %h want %h", c, rd_data, mem[c-15]);
        end
      end
      next_cycle();
    end
  endtask

  // Drop req in cycle 7 during AOUT.
  task automatic test_abort();
    logic [15:0] a = 16'h1234;
    for (int c = 0; c <= 9; c++) begin
      req = (c < 7); wr = 1'b0;
      data = (c < 4) ? a[4*c +: 4] : 4'h0;
      sio_in = 4'h0;
      @(negedge clk);
      if (c != 7) begin
        checks++;
        if (cs_n !== !(c >= 4 && c <= 6)) begin
          errors++; $display("FAIL abort c%0d cs_n got %b want %b", c, cs_n, !(c >= 4 && c <= 6));
        end
      end
      checks++;
      if (ready !== (c == 0 || c == 9)) begin
        errors++; $display("FAIL abort c%0d ready got %b want %b", c, ready, (c == 0 || c == 9));
      end
      if (c >= 4 && c <= 6) begin
        checks++;
        if (sio_out !== exp_pin(c, 1'b0, a)) begin
          errors++;
          $display("FAIL abort c%0d sio_out got %h want %h", c, sio_out, exp_pin(c, 1'b0, a));
        end
      end
      if (c >= 8) begin
        checks++;
        if ({sck_en, sio_oe, rd_valid} !== 3'b000) begin
          errors++; $display("FAIL abort c%0d sck/oe/valid got %b want 000", c,
                             {sck_en, sio_oe, rd_valid});
        end
      end
      next_cycle();
    end
  endtask

  // First read ends with req low in 18; next request held from 19, accepted in 20.
  task automatic test_back_to_back();
    logic [15:0] a1 = 16'h1234;
    logic [15:0] a2 = 16'h5A5A;
    logic [3:0] mem [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    for (int c = 0; c <= 37; c++) begin
      logic exp_cs, exp_oe, exp_v, exp_rdy;
      logic [3:0] exp_rd;
      req = !(c == 18 || c >= 35); wr = 1'b0;
      if (c < 4) data = a1[4*c +: 4];
      else if (c >= 19 && c <= 23) data = a2[4*((c < 20) ? 0 : c - 20) +: 4];
      else data = 4'h0;
      if (c >= 14 && c <= 17) sio_in = mem[c-14];
      else if (c == 34) sio_in = 4'h9;
      else sio_in = 4'h0;
      @(negedge clk);
      exp_cs  = !((c >= 4 && c <= 17) || (c >= 24 && c <= 34));
      exp_oe  = (c >= 4 && c <= 11) || (c >= 24 && c <= 31);
      exp_v   = (c >= 15 && c <= 18) || (c == 35);
      exp_rdy = (c == 0 || c == 20 || c == 37);
      exp_rd  = (c == 35) ? 4'h9 : ((c >= 15 && c <= 18) ? mem[(c >= 15 && c <= 18) ? c-15 : 0]
                                                           : 4'h0);
      checks++;
      if (cs_n !== exp_cs) begin
        errors++; $display("FAIL b2b c%0d cs_n got %b want %b", c, cs_n, exp_cs);
      end
      checks++;
      if (sio_oe !== exp_oe) begin
        errors++; $display("FAIL b2b c%0d oe got %b want %b", c, sio_oe, exp_oe);
      end
      checks++;
      if (ready !== exp_rdy) begin
        errors++; $display("FAIL b2b c%0d ready got %b want %b", c, ready, exp_rdy);
      end
      checks++;
      if (rd_valid !== exp_v) begin
        errors++; $display("FAIL b2b c%0d rd_valid got %b want %b", c, rd_valid, exp_v);
      end
      if (exp_oe) begin
        checks++;
        if (sio_out !== ((c < 20) ? exp_pin(c, 1'b0, a1) : exp_pin(c - 20, 1'b0, a2))) begin
          errors++; $display("FAIL b2b c%0d sio_out got %h", c, sio_out);
        end
      end
      if (exp_v) begin
        checks++;
        if (rd_data !== exp_rd) begin
          errors++; $display("FAIL b2b c%0d rd_data got %h want %h", c, rd_data, exp_rd);
        end
      end
      next_cycle();
    end
  endtask

  // Reset in cycle 16 of a read, then a fresh read at 0x0010.
  task automatic test_reset_mid();
    logic [15:0] a = 16'h1234;
    logic [15:0] b = 16'h0010;
    for (int c = 0; c <= 17; c++) begin
      rst = (c == 16); req = (c <= 16); wr = 1'b0;
      data = (c < 4) ? a[4*c +: 4] : 4'h0;
      sio_in = (c >= 14) ? 4'hE : 4'h0;
      @(negedge clk);
      if (c == 16) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 4'hE) begin
          errors++; $display("FAIL rstmid c16 valid/data got %b/%h want 1/e", rd_valid, rd_data);
        end
      end
      if (c == 17) begin
        checks++;
        if ({ready, cs_n, sck_en, sio_oe, rd_valid, wr_ready} !== 6'b110000) begin
          errors++;
          $display("FAIL rstmid ctrl got %b want 110000",
                   {ready, cs_n, sck_en, sio_oe, rd_valid, wr_ready});
        end
        checks++;
        if ({sio_out, rd_data} !== 8'h00) begin
          errors++; $display("FAIL rstmid data got %h want 00", {sio_out, rd_data});
        end
      end
      next_cycle();
    end
    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      req = (k <= 14); wr = 1'b0;
      data = (k < 4) ? b[4*k +: 4] : 4'h0;
      sio_in = (k == 14) ? 4'h6 : 4'h0;
      @(negedge clk);
      checks++;
      if (cs_n !== !(k >= 4 && k <= 14)) begin
        errors++; $display("FAIL rstmid k%0d cs_n got %b want %b", k, cs_n, !(k >= 4 && k <= 14));
      end
      if (k >= 4 && k <= 11) begin
        checks++;
        if (sio_out !== exp_pin(k, 1'b0, b)) begin
          errors++;
          $display("FAIL rstmid k%0d sio_out got %h want %h", k, sio_out, exp_pin(k, 1'b0, b));
        end
      end
      checks++;
      if (rd_valid !== (k == 15)) begin
        errors++; $display("FAIL rstmid k%0d rd_valid got %b want %b", k, rd_valid, (k == 15));
      end
      if (k == 15) begin
        checks++;
        if (rd_data !== 4'h6) begin
          errors++; $display("FAIL rstmid k15 rd_data got %h want 6", rd_data);
        end
      end
      next_cycle();
    end
  endtask

`ifdef IDLI_SQI_WRITE_EN
  // Write at 0xBEEF with data 5,6 in cycles 12..13, req drops in 14.
  task automatic test_write();
    logic [15:0] a = 16'hBEEF;
    for (int c = 0; c <= 16; c++) begin
      logic [3:0] exp_out;
      req = (c <= 13); wr = (c == 0);
      if (c < 4) data = a[4*c +: 4];
      else if (c == 12) data = 4'h5;
      else if (c == 13) data = 4'h6;
      else data = 4'h0;
      sio_in = 4'h0;
      @(negedge clk);
      exp_out = (c == 12) ? 4'h5 : ((c == 13) ? 4'h6 : exp_pin(c, 1'b1, a));
      checks++;
      if (cs_n !== !(c >= 4 && c <= 13)) begin
        errors++; $display("FAIL write c%0d cs_n got %b want %b", c, cs_n, !(c >= 4 && c <= 13));
      end
      checks++;
      if (sio_oe !== (c >= 4 && c <= 13)) begin
        errors++; $display("FAIL write c%0d oe got %b want %b", c, sio_oe, (c >= 4 && c <= 13));
      end
      checks++;
      if (wr_ready !== (c == 12 || c == 13)) begin
        errors++; $display("FAIL write c%0d wr_ready got %b want %b", c, wr_ready,
                           (c == 12 || c == 13));
      end
      checks++;
      if (rd_valid !== 1'b0) begin
        errors++; $display("FAIL write c%0d rd_valid got %b want 0", c, rd_valid);
      end
      checks++;
      if (ready !== (c == 0 || c == 16)) begin
        errors++; $display("FAIL write c%0d ready got %b want %b", c, ready, (c == 0 || c == 16));
      end
      if (c >= 4 && c <= 13) begin
        checks++;
        if (sio_out !== exp_out) begin
          errors++; $display("FAIL write c%0d sio_out got %h want %h", c, sio_out, exp_out);
        end
      end
      next_cycle();
    end
  endtask
`else
  // Write request at 0x0010 with writes disabled behaves as a read.
  task automatic test_wr_ignored();
    logic [15:0] a = 16'h0010;
    for (int c = 0; c <= 17; c++) begin
      req = (c <= 14); wr = 1'b1;
      data = (c < 4) ? a[4*c +: 4] : 4'h0;
      sio_in = (c == 14) ? 4'h7 : 4'h0;
      @(negedge clk);
      checks++;
      if (cs_n !== !(c >= 4 && c <= 14)) begin
        errors++; $display("FAIL wrdis c%0d cs_n got %b want %b", c, cs_n, !(c >= 4 && c <= 14));
      end
      checks++;
      if (sio_oe !== (c >= 4 && c <= 11)) begin
        errors++; $display("FAIL wrdis c%0d oe got %b want %b", c, sio_oe, (c >= 4 && c <= 11));
      end
      checks++;
      if (wr_ready !== 1'b0) begin
        errors++; $display("FAIL wrdis c%0d wr_ready got %b want 0", c, wr_ready);
      end
      checks++;
      if (rd_valid !== (c == 15)) begin
        errors++; $display("FAIL wrdis c%0d rd_valid got %b want %b", c, rd_valid, (c == 15));
      end
      checks++;
      if (ready !== (c == 0 || c == 17)) begin
        errors++; $display("FAIL wrdis c%0d ready got %b want %b", c, ready, (c == 0 || c == 17));
      end
      if (c >= 4 && c <= 11) begin
        checks++;
        if (sio_out !== exp_pin(c, 1'b0, a)) begin
          errors++;
          $display("FAIL wrdis c%0d sio_out got %h want %h", c, sio_out, exp_pin(c, 1'b0, a));
        end
      end
      if (c == 15) begin
        checks++;
        if (rd_data !== 4'h7) begin
          errors++; $display("FAIL wrdis c15 rd_data got %h want 7", rd_data);
        end
      end
      next_cycle();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef IDLI_SQI_WRITE_EN
    test_write();
`else
    test_wr_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
